// File: rtl/mem_arbiter_pkg.sv
// Shared types and default constants for the main-memory arbiter.
// Optional fairness feature is selected with the ARB_FAIR_EN macro.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_MAX_DSTREAK = 4;

    // True while the RAM port is being driven for an access.
    function automatic logic in_access(input arb_state_t s);
        return (s == IACC) || (s == DACC);
    endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Access watchdog: clear/enable counter that saturates at TIMEOUT-1
// and flags expiry when it gets there.
module arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Counts 0 .. TIMEOUT-1, so clog2(TIMEOUT) bits suffice (minimum one bit).
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_r;

    // Cycle counter for the current access, held at its last value once expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {TW{1'b0}};
        end else if (clr) begin
            count_r <= {TW{1'b0}};
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one RAM port between instruction fetch and data access.
// Data has priority; a watchdog turns a hung access into an error completion.
// Define ARB_FAIR_EN to bound how many data grants can starve a waiting fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              err
);

    // Parameter range guard, evaluated at elaboration.
    if (TIMEOUT < 1 || MAX_DSTREAK < 1) begin : g_bad_param
        $error("mem_arbiter: TIMEOUT and MAX_DSTREAK must be at least 1");
    end

    arb_state_t        state_r;
    arb_owner_t        owner_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] store_r;
    logic [DATA_W-1:0] iload_r;
    logic [DATA_W-1:0] dload_r;
    logic              ihit_r;
    logic              dhit_r;
    logic              err_r;
    logic              ren_r;
    logic              wen_r;
    logic              grant_d_s;
    logic              grant_i_s;
    logic              timer_clr_s;
    logic              timer_en_s;
    logic              expired_s;

`ifdef ARB_FAIR_EN
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    logic [SW-1:0] streak_r;
`endif

    // Grant selection in IDLE: data first, unless a fetch has been starved too long.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (dREN || dWEN) begin
            grant_d_s = 1'b1;
        end else if (iREN) begin
            grant_i_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
        end
`ifdef ARB_FAIR_EN
        if (iREN && (streak_r == SW'(MAX_DSTREAK))) begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b1;
        end else begin
            grant_i_s = grant_i_s;
        end
`endif
    end

    assign timer_en_s  = in_access(state_r);
    assign timer_clr_s = !in_access(state_r);

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst     (RST),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // Arbiter FSM with registered RAM strobes, hit pulses and returned data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= IDLE;
            owner_r  <= OWN_I;
            addr_r   <= {ADDR_W{1'b0}};
            store_r  <= {DATA_W{1'b0}};
            iload_r  <= {DATA_W{1'b0}};
            dload_r  <= {DATA_W{1'b0}};
            ihit_r   <= 1'b0;
            dhit_r   <= 1'b0;
            err_r    <= 1'b0;
            ren_r    <= 1'b0;
            wen_r    <= 1'b0;
`ifdef ARB_FAIR_EN
            streak_r <= {SW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    ihit_r <= 1'b0;
                    dhit_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (grant_d_s) begin
                        // A combined read+write request is performed as a write.
                        addr_r  <= daddr;
                        store_r <= dstore;
                        owner_r <= OWN_D;
                        ren_r   <= !dWEN;
                        wen_r   <= dWEN;
                        state_r <= DACC;
`ifdef ARB_FAIR_EN
                        if (iREN) begin
                            streak_r <= streak_r + SW'(1);
                        end else begin
                            streak_r <= streak_r;
                        end
`endif
                    end else if (grant_i_s) begin
                        addr_r  <= iaddr;
                        owner_r <= OWN_I;
                        ren_r   <= 1'b1;
                        wen_r   <= 1'b0;
                        state_r <= IACC;
`ifdef ARB_FAIR_EN
                        streak_r <= {SW{1'b0}};
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IACC, DACC: begin
                    if (ram_ready) begin
                        if (owner_r == OWN_D) begin
                            dload_r <= ramload;
                        end else begin
                            iload_r <= ramload;
                        end
                        ihit_r  <= (owner_r == OWN_I);
                        dhit_r  <= (owner_r == OWN_D);
                        err_r   <= 1'b0;
                        ren_r   <= 1'b0;
                        wen_r   <= 1'b0;
                        state_r <= DONE;
                    end else if (expired_s) begin
                        if (owner_r == OWN_D) begin
                            dload_r <= {DATA_W{1'b0}};
                        end else begin
                            iload_r <= {DATA_W{1'b0}};
                        end
                        ihit_r  <= (owner_r == OWN_I);
                        dhit_r  <= (owner_r == OWN_D);
                        err_r   <= 1'b1;
                        ren_r   <= 1'b0;
                        wen_r   <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DONE: begin
                    // One-cycle gap so a still-held request is not granted twice.
                    ihit_r  <= 1'b0;
                    dhit_r  <= 1'b0;
                    err_r   <= 1'b0;
                    ren_r   <= 1'b0;
                    wen_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ihit_r  <= 1'b0;
                    dhit_r  <= 1'b0;
                    err_r   <= 1'b0;
                    ren_r   <= 1'b0;
                    wen_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ihit     = ihit_r;
    assign dhit     = dhit_r;
    assign err      = err_r;
    assign iload    = iload_r;
    assign dload    = dload_r;
    assign ramREN   = ren_r;
    assign ramWEN   = wen_r;
    assign ramaddr  = addr_r;
    assign ramstore = store_r;

endmodule
